// File: rtl/dbus_sram_responder_if.sv
// Data-side memory bus between the pipeline memory stage (master) and a
// memory responder (slave).
//   busaddr    byte address, [1:0] select the byte lane
//   rd_req     read request, held until rw_wait is low
//   wr_req     write request, held until rw_wait is low
//   data_size  3'b001 byte, 3'b010 halfword, 3'b100 word
//   wr_data    write data, already replicated across lanes by the master
//   rw_wait    high = hold the request; low with a request = completes now
//   rd_data    full aligned word, valid in the completing cycle
//   bus_err    one-cycle pulse after an out-of-window access completes
interface dbus_sram_responder_if;
  logic [31:0] busaddr;
  logic        rd_req;
  logic        wr_req;
  logic [2:0]  data_size;
  logic [31:0] wr_data;
  logic        rw_wait;
  logic [31:0] rd_data;
  logic        bus_err;

  modport master (
    output busaddr, rd_req, wr_req, data_size, wr_data,
    input  rw_wait, rd_data, bus_err
  );

  modport slave (
    input  busaddr, rd_req, wr_req, data_size, wr_data,
    output rw_wait, rd_data, bus_err
  );
endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word-organised on-chip SRAM.
// Services byte, halfword and word accesses with WAIT_CYCLES wait states
// per access (rw_wait handshake). Addresses outside the mapped window read
// as zero, drop writes and raise bus_err for one cycle after completion.
//
// Ports:
//   clk   clock, all state on the rising edge
//   Nrst  asynchronous active-low reset
//   bus   dbus_sram_responder_if slave side (request in, rw_wait/rd_data/bus_err out)
//
// Parameters:
//   ADDR_WIDTH   word-address bits (<= 29); array holds 2**ADDR_WIDTH words
//   BASE_ADDR    byte address of word 0, aligned to 4*2**ADDR_WIDTH
//   WAIT_CYCLES  wait states per access, 0..15
module dbus_sram_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  Nrst,
  dbus_sram_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  logic [31:0] mem [0:DEPTH-1];

  logic [3:0]  cnt_reg, cnt_next;
  logic [30:0] id_reg;
  logic        bus_err_reg;

  logic                  req;
  logic                  complete;
  logic                  in_range;
  logic                  wr_en;
  logic [30:0]           id_now;
  logic [31:2]           word_off;
  logic [ADDR_WIDTH-1:0] index;
  logic [3:0]            be;
  logic [31:0]           cur_word;
  logic [31:0]           wr_word;

  assign req    = bus.rd_req | bus.wr_req;
  // Same word and same direction = same access; a change restarts the wait.
  assign id_now = {bus.busaddr[31:2], bus.wr_req};

  // BASE_ADDR is window-aligned, so the window test only needs word bits.
  assign word_off = bus.busaddr[31:2] - BASE_ADDR[31:2];
  assign in_range = (word_off[31:ADDR_WIDTH+2] == '0);
  assign index    = word_off[ADDR_WIDTH+1:2];

  // Asynchronous array read: with zero wait states the word must be valid in
  // the same cycle the request is first presented.
  assign cur_word = mem[index];

  assign bus.rw_wait = req && (cnt_reg != WAIT_LIM);
  assign complete    = req && !bus.rw_wait;
  // Combined read+write still returns the pre-write word.
  assign bus.rd_data = (bus.rd_req && in_range) ? cur_word : 32'h0;
  assign bus.bus_err = bus_err_reg;

  // Nrst gating keeps a zero-wait request from writing while held in reset.
  assign wr_en = complete && bus.wr_req && in_range && Nrst;

  always_comb begin
    be = 4'b0000;
    case (bus.data_size)
      3'b001:  be = 4'b0001 << bus.busaddr[1:0];
      3'b010:  be = bus.busaddr[1] ? 4'b1100 : 4'b0011;
      3'b100:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Merge enabled lanes of the write data into the current word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_word[8*gi +: 8] = be[gi] ? bus.wr_data[8*gi +: 8] : cur_word[8*gi +: 8];
  end

  // Wait counter: cleared when idle, on completion, and when a different
  // access replaces one that was already waiting.
  always_comb begin
    cnt_next = cnt_reg;
    if (!req) begin
      cnt_next = 4'd0;
    end else if ((id_now != id_reg) && (cnt_reg != 4'd0)) begin
      cnt_next = 4'd0;
    end else if (cnt_reg < WAIT_LIM) begin
      cnt_next = cnt_reg + 4'd1;
    end else begin
      cnt_next = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      cnt_reg     <= 4'd0;
      id_reg      <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      id_reg      <= id_now;
      bus_err_reg <= complete && !in_range;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[index] <= wr_word;
    end
  end

endmodule
